// File: rtl/pixel_write_buffer_if.sv
// Framebuffer write port: address/data/write-enable offered by the buffer,
// accepted by the memory side with mem_ready.
interface pixel_write_buffer_if #(
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 12
);
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_we;
    logic               mem_ready;

    modport master (output mem_addr, output mem_data, output mem_we, input mem_ready);
    modport slave  (input mem_addr, input mem_data, input mem_we, output mem_ready);
endinterface

// File: rtl/pixel_write_buffer.sv
// Clips and linearises the view-mux pixel stream, buffers it in a FIFO and
// drains it to the framebuffer; also runs full-screen clear fills.
module pixel_write_buffer #(
    parameter int DEPTH   = 16,
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8:0]               in_x,
    input  logic [7:0]               in_y,
    input  logic [COLOR_W-1:0]       in_color,
    input  logic                     in_write,
    input  logic                     clear_req,
    input  logic [COLOR_W-1:0]       clear_color,
    pixel_write_buffer_if.master     mem,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               clip_count,
    output logic                     clear_done,
    output logic                     busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + COLOR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLR_WAIT, CLEAR} state_t;

    state_t state, state_nxt;

    logic [8:0]          s1_x;
    logic [7:0]          s1_y;
    logic [COLOR_W-1:0]  s1_color;
    logic                s1_write;
    logic                s1_clip;
    logic [ADDR_W-1:0]   s1_addr;
    logic [ADDR_W-1:0]   y_ext;

    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic [ENTRY_W-1:0]  head;
    logic                push, push_ok, pop, full, empty;

    logic [ADDR_W-1:0]   clr_cnt;
    logic [COLOR_W-1:0]  clr_color;
    logic                clr_last;
    logic                take_clear;

    logic [ADDR_W-1:0]   addr_o;
    logic [COLOR_W-1:0]  data_o;
    logic                we_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_x     <= '0;
            s1_y     <= '0;
            s1_color <= '0;
            s1_write <= 1'b0;
            s1_clip  <= 1'b0;
        end else begin
            s1_x     <= in_x;
            s1_y     <= in_y;
            s1_color <= in_color;
            s1_write <= in_write;
            s1_clip  <= (32'(in_x) >= H_RES) || (32'(in_y) >= V_RES);
        end
    end

    // y*320 as (y<<8)+(y<<6) keeps the address path multiplier-free
    assign y_ext   = ADDR_W'(s1_y);
    assign s1_addr = (y_ext << 8) + (y_ext << 6) + ADDR_W'(s1_x);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = s1_write && !s1_clip;
    assign push_ok = push && (!full || pop);
    assign head    = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {s1_addr, s1_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
            if (s1_write && s1_clip && clip_count != 8'hFF) clip_count <= clip_count + 1'b1;
        end
    end

    assign take_clear = clear_req && (state == IDLE || state == DRAIN);
    assign clr_last   = (clr_cnt == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            if (take_clear) clr_color <= clear_color;
            if (state == CLEAR && mem.mem_ready) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (clear_req)   state_nxt = CLR_WAIT;
                else if (!empty) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (clear_req)                                state_nxt = CLR_WAIT;
                else if (pop && count == ONE_CNT && !push_ok) state_nxt = IDLE;
            end
            CLR_WAIT: begin
                if (empty) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (mem.mem_ready && clr_last) state_nxt = empty ? IDLE : DRAIN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pixels buffered during CLEAR are held back until the fill completes
    always_comb begin
        we_o       = 1'b0;
        addr_o     = '0;
        data_o     = '0;
        pop        = 1'b0;
        clear_done = 1'b0;
        unique case (state)
            DRAIN, CLR_WAIT: begin
                if (!empty) begin
                    we_o   = 1'b1;
                    addr_o = head[ENTRY_W-1:COLOR_W];
                    data_o = head[COLOR_W-1:0];
                    pop    = mem.mem_ready;
                end
            end
            CLEAR: begin
                we_o       = 1'b1;
                addr_o     = clr_cnt;
                data_o     = clr_color;
                clear_done = mem.mem_ready && clr_last;
            end
            default: ;
        endcase
    end

    assign mem.mem_we   = we_o;
    assign mem.mem_addr = addr_o;
    assign mem.mem_data = data_o;
    assign fifo_count   = count;
    assign busy         = !empty || (state != IDLE);
endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: expected write stream kept as a queue
// of {addr,data} built from y*320+x and clear fills, checked on every accepted write.
module tb_pixel_write_buffer;
    logic        clk;
    logic        reset;
    logic [8:0]  in_x;
    logic [7:0]  in_y;
    logic [11:0] in_color;
    logic        in_write;
    logic        clear_req;
    logic [11:0] clear_color;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  clip_count;
    logic        clear_done;
    logic        busy;

    pixel_write_buffer_if #(.ADDR_W(17), .COLOR_W(12)) fb ();

    pixel_write_buffer #(
        .DEPTH(16), .H_RES(320), .V_RES(240), .COLOR_W(12), .ADDR_W(17)
    ) dut (
        .clk(clk), .reset(reset),
        .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_write(in_write),
        .clear_req(clear_req), .clear_color(clear_color),
        .mem(fb),
        .fifo_count(fifo_count), .overflow(overflow), .clip_count(clip_count),
        .clear_done(clear_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_writes = 0;
    int n_done = 0;
    int exp_clip = 0;
    logic [28:0] exp_q [$];
    logic [28:0] e;
    logic        stalled = 1'b0;
    logic [16:0] st_addr;
    logic [11:0] st_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic drive_px(input int x, input int y, input logic [11:0] c, input bit keep);
        @(posedge clk); #1;
        in_x = 9'(x); in_y = 8'(y); in_color = c; in_write = 1'b1;
        if (x >= 320 || y >= 240) begin
            if (exp_clip < 255) exp_clip++;
        end else if (keep) begin
            exp_q.push_back({17'(y * 320 + x), c});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_write = 1'b0; clear_req = 1'b0;
        end
    endtask

    task automatic wait_drained(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("drain_in_budget", 32'(k < budget), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, fb.mem_we, 0);
        chk({tag, "_addr"}, fb.mem_addr, 0);
        chk({tag, "_data"}, fb.mem_data, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_clip"}, clip_count, 0);
        chk({tag, "_done"}, clear_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard: every accepted write must be the next expected one, stalls must hold
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_we", fb.mem_we, 1);
                chk("hold_addr", fb.mem_addr, st_addr);
                chk("hold_data", fb.mem_data, st_data);
            end
            if (fb.mem_we && fb.mem_ready) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, want no write",
                             fb.mem_addr, fb.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", fb.mem_addr, e[28:12]);
                    chk("wr_data", fb.mem_data, e[11:0]);
                end
            end
            if (clear_done) begin
                n_done++;
                chk("done_addr", fb.mem_addr, 76799);
                chk("done_accept", 32'(fb.mem_we && fb.mem_ready), 1);
            end
            stalled = fb.mem_we && !fb.mem_ready;
            st_addr = fb.mem_addr;
            st_data = fb.mem_data;
        end
    end

    initial begin
        int w0, d0, k;
        reset = 1'b1; in_x = '0; in_y = '0; in_color = '0; in_write = 1'b0;
        clear_req = 1'b0; clear_color = '0; fb.mem_ready = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0; fb.mem_ready = 1'b1;

        // T1: single pixel latency and address
        drive_px(5, 2, 12'hF00, 1);
        idle(1);
        @(negedge clk); chk("t1_we_e0", fb.mem_we, 0);
        @(negedge clk); chk("t1_we_e1", fb.mem_we, 0);
        @(negedge clk);
        chk("t1_we_e2", fb.mem_we, 1);
        chk("t1_addr", fb.mem_addr, 645);
        chk("t1_data", fb.mem_data, 12'hF00);
        @(negedge clk);
        chk("t1_count", fifo_count, 0);
        chk("t1_busy", busy, 0);

        // T2: clipping at both edges, last valid pixel
        w0 = n_writes;
        drive_px(320, 0, 12'h111, 1);
        drive_px(0, 240, 12'h222, 1);
        drive_px(319, 239, 12'h333, 1);
        idle(1);
        wait_drained(50);
        chk("t2_clip", clip_count, 2);
        chk("t2_clip_model", clip_count, exp_clip);
        chk("t2_writes", n_writes - w0, 1);

        // T3: stalled port, 20 pixels into 16 entries
        @(posedge clk); #1; fb.mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) drive_px(i, 10, 12'(i + 1), i < 16);
        idle(3);
        @(negedge clk);
        chk("t3_count", fifo_count, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_we", fb.mem_we, 1);
        chk("t3_addr", fb.mem_addr, 3200);
        chk("t3_data", fb.mem_data, 1);
        w0 = n_writes;
        @(posedge clk); #1; fb.mem_ready = 1'b1;
        wait_drained(100);
        chk("t3_writes", n_writes - w0, 16);
        chk("t3_ovf_sticky", overflow, 1);

        // T5: mem_ready toggling every cycle while draining
        w0 = n_writes;
        for (int i = 0; i < 8; i++) begin
            drive_px(10 + i, 20 + i, 12'h0A0 + 12'(i), 1);
            fb.mem_ready = i[0];
        end
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            in_write = 1'b0;
            fb.mem_ready = !fb.mem_ready;
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("t5_drain_in_budget", 32'(k < 100), 1);
        chk("t5_writes", n_writes - w0, 8);

        // T4: clear with 3 queued pixels, a pixel and an ignored clear_req mid-fill
        @(posedge clk); #1; fb.mem_ready = 1'b0;
        drive_px(100, 50, 12'hABC, 1);
        drive_px(101, 50, 12'hABD, 1);
        drive_px(0, 0, 12'hABE, 1);
        idle(3);
        w0 = n_writes; d0 = n_done;
        @(posedge clk); #1;
        clear_req = 1'b1; clear_color = 12'h00F;
        for (int a = 0; a < 76800; a++) exp_q.push_back({17'(a), 12'h00F});
        @(posedge clk); #1;
        clear_req = 1'b0; clear_color = '0; fb.mem_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1; clear_req = 1'b1; clear_color = 12'h0F0;
        drive_px(7, 7, 12'h0AB, 1);
        idle(1);
        wait_drained(80000);
        chk("t4_writes", n_writes - w0, 76804);
        chk("t4_done_pulses", n_done - d0, 1);

        // T6: reset mid-clear
        @(posedge clk); #1;
        clear_req = 1'b1; clear_color = 12'h555;
        for (int a = 0; a < 76800; a++) exp_q.push_back({17'(a), 12'h555});
        @(posedge clk); #1; clear_req = 1'b0;
        repeat (50) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_all_zero("t6_reset");
        exp_q.delete();
        @(posedge clk); #1; reset = 1'b0;
        w0 = n_writes;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_writes", n_writes - w0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
